// File: rtl/sys_bus_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sys_bus_pkg
// Description : Shared types and constants for the system bus arbiter:
//               FSM state encoding, default bus widths, master indices.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_bus_pkg;

   // One transaction walks IDLE -> ISSUE -> WAIT -> RESP -> IDLE
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_t;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Requester slots on the arbiter
   localparam int MST_IFETCH = 0;
   localparam int MST_DATA   = 1;
   localparam int MST_DMA    = 2;

endpackage
`default_nettype wire

// File: rtl/rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Combinational round-robin picker. Searches the request
//               vector starting one slot above rr_ptr (wrapping modulo
//               NUM_MASTERS) and reports the first requester found.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
   import sys_bus_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int IDX_W       = 2
)(
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [IDX_W-1:0]       rr_ptr,
   output logic                   valid,
   output logic [IDX_W-1:0]       winner
);

   // Scan from farthest to nearest offset so the nearest requester after rr_ptr wins
   always_comb begin
      int cand;
      cand   = 0;
      valid  = 1'b0;
      winner = '0;
      for (int off = NUM_MASTERS; off >= 1; off--) begin
         cand = (int'(rr_ptr) + off) % NUM_MASTERS;
         if (req[cand]) begin
            valid  = 1'b1;
            winner = IDX_W'(cand);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/system_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : system_bus_arbiter
// Description : Round-robin arbiter sharing the single-port system bus among
//               NUM_MASTERS requesters. One read or write per grant, with a
//               one-cycle done pulse and shared read data.
//               Optional WAIT-state timeout enabled by SYS_BUS_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module system_bus_arbiter
   import sys_bus_pkg::*;
#(
   parameter int NUM_MASTERS = MST_DMA + 1,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int DATA_W      = DATA_W_DEF,
   parameter int TIMEOUT     = 16
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS-1:0]        m_we,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   output logic [NUM_MASTERS-1:0]        m_gnt,
   output logic [NUM_MASTERS-1:0]        m_done,
   output logic [NUM_MASTERS-1:0]        m_err,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [ADDR_W-1:0]             bus_addr,
   output logic [DATA_W-1:0]             bus_wdata,
   output logic                          bus_read_enable,
   output logic                          bus_write_enable,
   input  logic [DATA_W-1:0]             bus_rdata,
   input  logic                          bus_ready
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT < 1) begin : g_bad_params
      $error("system_bus_arbiter: parameter out of range");
   end

   arb_state_t       state;
   arb_state_t       state_nxt;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] owner;
   logic             owner_we;
   logic             pick_valid;
   logic [IDX_W-1:0] pick_idx;
   logic             wait_done;
   logic             wait_err;

   rr_priority_picker #(
      .NUM_MASTERS (NUM_MASTERS),
      .IDX_W       (IDX_W)
   ) u_picker (
      .req    (m_req),
      .rr_ptr (rr_ptr),
      .valid  (pick_valid),
      .winner (pick_idx)
   );

`ifdef SYS_BUS_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;

   // Count WAIT cycles; cleared while in ISSUE so each WAIT entry starts at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= '0;
      else if (state == ST_ISSUE)
         wait_cnt <= '0;
      else if (state == ST_WAIT)
         wait_cnt <= wait_cnt + 1'b1;
   end

   // Give up after TIMEOUT WAIT cycles without a ready from the bus
   assign wait_err = (state == ST_WAIT) && !bus_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT - 1));

   // Error pulse rides alongside the done pulse for the timed-out owner
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         m_err <= '0;
      else if (wait_done)
         m_err <= wait_err ? (NUM_MASTERS'(1) << owner) : '0;
      else if (state == ST_RESP)
         m_err <= '0;
   end
`else
   assign wait_err = 1'b0;
   assign m_err    = '0;
`endif

   assign wait_done = (state == ST_WAIT) && (bus_ready || wait_err);

   // State register; asynchronous reset abandons any transaction in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (pick_valid) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Bus strobes: exactly the single ISSUE cycle, direction from the latched owner
   always_comb begin
      bus_read_enable  = 1'b0;
      bus_write_enable = 1'b0;
      if (state == ST_ISSUE) begin
         bus_read_enable  = !owner_we;
         bus_write_enable = owner_we;
      end
   end

   // Latch the winner's request on grant, capture the response, clear on RESP exit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr    <= IDX_W'(NUM_MASTERS - 1);
         owner     <= '0;
         owner_we  <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         m_gnt     <= '0;
         m_done    <= '0;
         m_rdata   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner     <= pick_idx;
                  owner_we  <= m_we[pick_idx];
                  bus_addr  <= m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                  bus_wdata <= m_wdata[int'(pick_idx)*DATA_W +: DATA_W];
                  rr_ptr    <= pick_idx;
                  m_gnt     <= NUM_MASTERS'(1) << pick_idx;
               end
            end
            ST_WAIT: begin
               if (wait_done) begin
                  m_rdata <= (owner_we || wait_err) ? '0 : bus_rdata;
                  m_done  <= NUM_MASTERS'(1) << owner;
               end
            end
            ST_RESP: begin
               m_done <= '0;
               m_gnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
